// File: rtl/seg_display_scheduler.sv
// Round-robin owner scheduler for the shared 7-segment display, with a blank gap between owners.
// Define SCHED_PRIORITY_EN to make source 0 preempt other owners and win every arbitration.
module seg_display_scheduler #(
   parameter int DWELL_WIDTH  = 20,
   parameter int BLANK_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [2:0] req_i,
   input  logic [7:0] src0_seg_i,
   input  logic [7:0] src1_seg_i,
   input  logic [7:0] src2_seg_i,
   input  logic [1:0] dwell_sel_i,
   input  logic       hold_i,
   output logic [2:0] grant_o,
   output logic [7:0] seg_out_o,
   output logic       switch_pulse_o
);

   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   state_t                 state_q;
   logic [2:0]             grant_q;
   logic [7:0]             seg_q;
   logic                   pulse_q;
   logic [DWELL_WIDTH-1:0] cnt_q;
   logic [BW-1:0]          blank_q;
   logic [1:0]             last_q;

   logic [DWELL_WIDTH-1:0] tc;
   logic [1:0]             pick_d;
   logic [2:0]             pick_oh;
   logic                   owner_req, others_req, preempt, expired, leave;
   logic [7:0]             owner_seg;

   // (sel+1)*2^(W-2)-1 is just sel followed by W-2 ones
   assign tc = {dwell_sel_i, {(DWELL_WIDTH-2){1'b1}}};

   always_comb begin
      pick_d = 2'd0;
      case (last_q)
         2'd0:    pick_d = req_i[1] ? 2'd1 : (req_i[2] ? 2'd2 : 2'd0);
         2'd1:    pick_d = req_i[2] ? 2'd2 : (req_i[0] ? 2'd0 : 2'd1);
         default: pick_d = req_i[0] ? 2'd0 : (req_i[1] ? 2'd1 : 2'd2);
      endcase
`ifdef SCHED_PRIORITY_EN
      if (req_i[0]) pick_d = 2'd0;
`endif
   end

   assign pick_oh    = 3'b001 << pick_d;
   assign owner_req  = |(req_i & grant_q);
   assign others_req = |(req_i & ~grant_q);
   assign expired    = (cnt_q >= tc);
`ifdef SCHED_PRIORITY_EN
   assign preempt    = req_i[0] && (last_q != 2'd0);
`else
   assign preempt    = 1'b0;
`endif
   assign leave      = !owner_req || preempt || (expired && others_req);

   always_comb begin
      case (last_q)
         2'd0:    owner_seg = src0_seg_i;
         2'd1:    owner_seg = src1_seg_i;
         default: owner_seg = src2_seg_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         grant_q <= 3'b000;
         seg_q   <= 8'hFF;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
         blank_q <= '0;
         last_q  <= 2'd2;
      end else begin
         pulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               grant_q <= 3'b000;
               seg_q   <= 8'hFF;
               if (|req_i) begin
                  state_q <= SHOW;
                  grant_q <= pick_oh;
                  last_q  <= pick_d;
                  cnt_q   <= '0;
                  pulse_q <= 1'b1;
               end
            end
            SHOW: begin
               if (leave) begin
                  state_q <= BLANK;
                  grant_q <= 3'b000;
                  seg_q   <= 8'hFF;
                  blank_q <= '0;
               end else begin
                  seg_q <= ~owner_seg;
                  // uncontested owner simply restarts its dwell
                  if (expired)      cnt_q <= '0;
                  else if (!hold_i) cnt_q <= cnt_q + 1'b1;
               end
            end
            BLANK: begin
               seg_q <= 8'hFF;
               if (blank_q == BW'(BLANK_CYCLES-1)) begin
                  if (|req_i) begin
                     state_q <= SHOW;
                     grant_q <= pick_oh;
                     last_q  <= pick_d;
                     cnt_q   <= '0;
                     pulse_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  blank_q <= blank_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= 3'b000;
               seg_q   <= 8'hFF;
            end
         endcase
      end
   end

   assign grant_o        = grant_q;
   assign seg_out_o      = seg_q;
   assign switch_pulse_o = pulse_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: per-cycle reference model plus directed literal checks.
module tb_seg_display_scheduler;

   localparam int DW = 6;
   localparam int BC = 4;

   logic       clk = 1'b0;
   logic       reset, hold;
   logic [2:0] req;
   logic [7:0] s0, s1, s2;
   logic [1:0] dsel;
   logic [2:0] grant;
   logic [7:0] seg;
   logic       pulse;

   int n_pass = 0;
   int n_chk  = 0;

   seg_display_scheduler #(.DWELL_WIDTH(DW), .BLANK_CYCLES(BC)) dut (
      .clk_i(clk), .reset_i(reset), .req_i(req),
      .src0_seg_i(s0), .src1_seg_i(s1), .src2_seg_i(s2),
      .dwell_sel_i(dsel), .hold_i(hold),
      .grant_o(grant), .seg_out_o(seg), .switch_pulse_o(pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // reference model: phase 0 idle, 1 showing, 2 blanking
   int         m_phase, m_owner, m_last, m_cnt, m_left;
   logic [2:0] e_grant;
   logic [7:0] e_seg;
   logic       e_pulse;
   bit         m_valid = 0;

   function automatic int rr_pick(input logic [2:0] r, input int last);
`ifdef SCHED_PRIORITY_EN
      if (r[0]) return 0;
`endif
      for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
      return -1;
   endfunction

   always @(posedge clk) begin
      int         prev_owner, tc;
      bit         leave, arb;
      logic [7:0] src [3];
      src[0] = s0; src[1] = s1; src[2] = s2;
      prev_owner = m_owner;
      if (reset) begin
         m_phase = 0; m_owner = -1; m_last = 2; m_cnt = 0; m_left = 0;
         e_pulse = 1'b0; m_valid = 1;
      end else begin
         e_pulse = 1'b0;
         if (m_phase == 1) begin
            tc = (int'(dsel) + 1) * (1 << (DW - 2)) - 1;
            leave = !req[m_owner] || (m_cnt >= tc && (req & ~(3'b001 << m_owner)) != 3'b000);
`ifdef SCHED_PRIORITY_EN
            if (m_owner != 0 && req[0]) leave = 1;
`endif
            if (leave) begin m_phase = 2; m_owner = -1; m_left = BC; end
            else if (m_cnt >= tc) m_cnt = 0;
            else if (!hold) m_cnt++;
         end else begin
            arb = (m_phase == 0);
            if (m_phase == 2) begin m_left--; arb = (m_left == 0); end
            if (arb) begin
               if (req != 3'b000) begin
                  m_owner = rr_pick(req, m_last); m_last = m_owner;
                  m_cnt = 0; m_phase = 1; e_pulse = 1'b1;
               end else m_phase = 0;
            end
         end
      end
      e_grant = (m_owner < 0) ? 3'b000 : 3'(3'b001 << m_owner);
      e_seg   = (m_owner >= 0 && m_owner == prev_owner) ? ~src[m_owner] : 8'hFF;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_grant", 32'(grant), 32'(e_grant));
         chk("model_seg",   32'(seg),   32'(e_seg));
         chk("model_pulse", 32'(pulse), 32'(e_pulse));
      end
   end

   task automatic measure_run(output logic [2:0] g, output int len);
      g = grant; len = 1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (grant !== g) return;
         len++;
      end
      chk("run_timeout", 32'(len), 32'd0);
   endtask

   task automatic reset_with(input logic [2:0] r);
      req = r; hold = 1'b0; dsel = 2'd0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   logic [2:0] g;
   int         len, npulse, nbad;
   logic [2:0] tg [5] = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
   int         tl [5] = '{4, 16, 4, 16, 4};

   initial begin
      reset = 1'b1; req = 3'b111; hold = 1'b0; dsel = 2'd0;
      s0 = 8'h01; s1 = 8'h5A; s2 = 8'h80;

      // 1: reset state and first grant
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_seg",   32'(seg),   32'hFF);
      chk("rst_pulse", 32'(pulse), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("first_grant", 32'(grant), 32'h1);
      chk("first_pulse", 32'(pulse), 32'h1);

      // 2: single source holds without blanking
      req = 3'b001;
      @(negedge clk);
      chk("single_seg", 32'(seg), 32'hFE);
      npulse = 0; nbad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pulse) npulse++;
         if (grant !== 3'b001) nbad++;
      end
      chk("single_pulses", 32'(npulse), 32'd0);
      chk("single_lost",   32'(nbad),   32'd0);

      // 3: round robin through all three
      req = 3'b111; s1 = 8'h3C;
      measure_run(g, len);
      chk("rr_start_owner", 32'(g), 32'h1);
`ifndef SCHED_PRIORITY_EN
      for (int i = 0; i < 5; i++) begin
         measure_run(g, len);
         chk("rr_owner", 32'(g), 32'(tg[i]));
         chk("rr_len",   32'(len), 32'(tl[i]));
      end
      dsel = 2'd3;
      measure_run(g, len);
      chk("rr_long_owner", 32'(g), 32'h1);
      chk("rr_long_len",   32'(len), 32'd64);
`endif

      // 4: owner drops its request mid-dwell
      reset_with(3'b011);
      chk("drop_owner", 32'(grant), 32'h1);
      repeat (5) @(negedge clk);
      req = 3'b010;
      @(negedge clk);
      chk("drop_blank", 32'(grant), 32'h0);
      measure_run(g, len);
      chk("drop_blank_len", 32'(len), 32'd4);
      chk("drop_next", 32'(grant), 32'h2);

      // 5: hold freezes the dwell count
      reset_with(3'b011);
      repeat (3) @(negedge clk);
      hold = 1'b1;
      repeat (100) @(negedge clk);
      chk("hold_owner", 32'(grant), 32'h1);
      hold = 1'b0;
      measure_run(g, len);
      chk("hold_more", 32'(len - 1), 32'd12);

      // 6: source 0 arriving while source 1 shows
      reset_with(3'b010);
      chk("pri_owner", 32'(grant), 32'h2);
      repeat (2) @(negedge clk);
      req = 3'b011;
`ifdef SCHED_PRIORITY_EN
      @(negedge clk);
      chk("pri_preempt", 32'(grant), 32'h0);
`else
      measure_run(g, len);
      chk("pri_rest_len", 32'(len), 32'd14);
`endif
      measure_run(g, len);
      chk("pri_blank_len", 32'(len), 32'd4);
      chk("pri_next", 32'(grant), 32'h1);

      // reset in the middle of a dwell
      req = 3'b111;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_grant", 32'(grant), 32'h0);
      chk("midrst_seg",   32'(seg),   32'hFF);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_regrant", 32'(grant), 32'h1);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Round-robin scheduler sharing the single 7-segment display (8 segment lines) between three pattern sources: spinner/chaser, digit counter and status blink.
- Each source raises a request; the block grants one owner at a time and gives it a programmable dwell time.
- Between owners the display is blanked for a fixed gap.
- Drives the active-low segment outputs that go straight to io_out.

Parameters:
- DWELL_WIDTH, 20, width of dwell counter; dwell unit = 2^(DWELL_WIDTH-2) cycles.
- BLANK_CYCLES, 4, display-off cycles between owners (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  3  per-source display request, bit i = source i
- src0_seg  input  8  source 0 pattern, active-high segments
- src1_seg  input  8  source 1 pattern, active-high segments
- src2_seg  input  8  source 2 pattern, active-high segments
- dwell_sel  input  2  dwell length select, sampled live
- hold  input  1  freeze dwell counter on current owner
- grant  output  3  one-hot current owner, 000 when none
- seg_out  output  8  registered active-low segments, ~selected source
- switch_pulse  output  1  one-cycle pulse when a new grant starts

Behaviour:
- Reset, synchronous and active-high, wins over all other inputs:
  - state=IDLE, grant=000, seg_out=8'hFF, switch_pulse=0.
  - dwell counter=0, blank counter=0.
  - last-owner pointer=2, so source 0 wins the first arbitration.
- Dwell terminal count: TC = (dwell_sel+1)*2^(DWELL_WIDTH-2) - 1. Arithmetic is DWELL_WIDTH bits; the maximum fits exactly.
- Round-robin pick: the first asserted req bit after the last-owner pointer, searching cyclically (last+1, last+2, last).
- IDLE:
  - grant=000, seg_out=8'hFF.
  - If any req is sampled high, go to SHOW at the next edge. grant=pick, counter=0, switch_pulse=1 for that cycle, pointer=pick.
- SHOW:
  - Counter increments each cycle unless hold=1.
  - If the owner's req is sampled low: go to BLANK at the next edge. This happens regardless of hold or count.
  - If counter>=TC and another source requests: go to BLANK. Using >= means a dwell_sel decrease mid-dwell expires at once.
  - If counter>=TC and no other source requests: counter=0 and the same owner stays. There is no blank and no switch_pulse.
- BLANK:
  - grant=000, seg_out=8'hFF.
  - Lasts exactly BLANK_CYCLES cycles, then arbitrates.
  - Any req high: go to SHOW with the RR pick and switch_pulse=1.
  - No req: go to IDLE.
- Latency:
  - req high at edge N gives grant valid after edge N (from IDLE).
  - seg_out reflects the granted source from the following edge and tracks source changes with one-cycle register latency.
- Grant is always one-hot or zero. seg_out is 8'hFF whenever grant=000.
- A SHOW period for an uncontested-then-contested owner lasts TC+1 cycles, plus one cycle of seg_out lag.
- Reset asserted mid-SHOW or mid-BLANK returns to the reset state at the next edge. Pending requests are re-arbitrated from pointer=2.

Optional Feature:
- Macro SCHED_PRIORITY_EN.
- Defined: source 0 is high priority.
  - In SHOW with owner!=0 and req[0]=1, go to BLANK at the next edge, ignoring dwell count and hold.
  - Every arbitration picks source 0 when req[0]=1. The RR pointer is still updated to the granted source.
- Undefined: pure round-robin as above, with no preemption.

Test Plan (DWELL_WIDTH=6 so TC=15 at dwell_sel=0; BLANK_CYCLES=4):
1. Reset: reset=1 for 2 cycles with req=111 -> grant=000, seg_out=8'hFF, switch_pulse=0. Release -> grant=001 with switch_pulse=1 next cycle.
2. Single source: req=001, src0_seg=8'h01 -> grant=001, seg_out=8'hFE one cycle later. Holds for 200 cycles with no blank and no further switch_pulse.
3. Round-robin: req=111, dwell_sel=0 -> sequence 001 (16 cycles), 000 (4), 010 (16), 000 (4), 100 (16), 000 (4), 001. dwell_sel=3 -> 64-cycle owners.
4. Owner drop: req=011, owner 0; drop req[0] at count 5 -> grant=000 next edge, 4 blank cycles, then grant=010.
5. Hold: req=011, owner 0; hold=1 at count 3 for 100 cycles -> grant stays 001. Release -> switch after 12 more SHOW cycles.
6. SCHED_PRIORITY_EN: owner 1 at count 2; raise req[0] -> grant=000 next edge, 4 blank cycles, then 001. Without the macro -> owner 1 completes its 16 cycles.
